// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, control codes and FSM state type for the text buffer
//
// Purpose: geometry defaults, fill code, byte codes recognised by the write
// port, and the controller state enum used by text_buffer.
package text_pkg;

    localparam int          COLS    = 32;
    localparam int          ROWS    = 16;
    localparam logic [7:0]  FILL    = 8'h20;

    localparam logic [7:0]  C_LF    = 8'h0A;
    localparam logic [7:0]  C_CR    = 8'h0D;
    localparam logic [7:0]  C_BS    = 8'h08;
    localparam logic [7:0]  C_PR_LO = 8'h20;
    localparam logic [7:0]  C_PR_HI = 8'h7E;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } state_e;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= C_PR_LO) && (b <= C_PR_HI);
    endfunction

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - 512x8 simple dual-port cell RAM with registered read port
//
// Purpose: character cell storage. One write port, one read port whose
// output register returns the old contents when read and write hit the same
// address in the same cycle. Array contents are never reset; only the read
// register is.
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset of the read register
//   we_i/waddr_i/wdata_i   write port
//   raddr_i          read address, sampled on the rising edge
//   rdata_o          read data, valid the cycle after raddr_i is sampled
module text_ram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads the array before this edge's write lands: old data on collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - character-cell text buffer with cursor, scrolling and clear
//
// Purpose: answers draw's cell reads (CX,CY -> CHAR, one cycle latency) and
// prints a byte stream into the screen with cursor advance, line wrap,
// CR/LF, backspace, scroll via a top-row offset and full-screen clear.
// Ports:
//   CLK, NRST          clock, asynchronous active-low reset
//   CX, CY, CHAR       read column / screen row, registered character out
//   WDATA, WVALID, WREADY   byte write handshake
//   CLR                level-sensitive synchronous clear request
//   CURX, CURY         cursor column / screen row
module text_buffer #(
    parameter int         COLS = text_pkg::COLS,
    parameter int         ROWS = text_pkg::ROWS,
    parameter logic [7:0] FILL = text_pkg::FILL
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic [4:0] CX,
    input  logic [3:0] CY,
    output logic [7:0] CHAR,
    input  logic [7:0] WDATA,
    input  logic       WVALID,
    output logic       WREADY,
    input  logic       CLR,
    output logic [4:0] CURX,
    output logic [3:0] CURY
);

    import text_pkg::state_e;
    import text_pkg::CLR_ALL;
    import text_pkg::IDLE;
    import text_pkg::CLR_ROW;
    import text_pkg::C_LF;
    import text_pkg::C_CR;
    import text_pkg::C_BS;
    import text_pkg::is_print;

    localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
    localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
    localparam logic [8:0] LAST_CELL = 9'(COLS * ROWS - 1);

    state_e     state_q,   state_d;
    logic [3:0] top_q,     top_d;
    logic [4:0] curx_q,    curx_d;
    logic [3:0] cury_q,    cury_d;
    logic [3:0] crow_q,    crow_d;
    logic [8:0] clr_cnt_q, clr_cnt_d;
    logic [4:0] row_cnt_q, row_cnt_d;

    logic       accept;
    logic       newline;
    logic       ram_we;
    logic [8:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [3:0] cur_prow;
    logic [3:0] rd_prow;

    // Screen rows map onto physical rows rotated by the top offset.
    assign cur_prow = cury_q + top_q;
    assign rd_prow  = CY + top_q;

    assign WREADY = (state_q == IDLE) && !CLR;
    assign accept = WVALID && WREADY;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q   <= CLR_ALL;
            top_q     <= '0;
            curx_q    <= '0;
            cury_q    <= '0;
            crow_q    <= '0;
            clr_cnt_q <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            top_q     <= top_d;
            curx_q    <= curx_d;
            cury_q    <= cury_d;
            crow_q    <= crow_d;
            clr_cnt_q <= clr_cnt_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        top_d     = top_q;
        curx_d    = curx_q;
        cury_d    = cury_q;
        crow_d    = crow_q;
        clr_cnt_d = clr_cnt_q;
        row_cnt_d = row_cnt_q;
        newline   = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = {cur_prow, curx_q};
        ram_wdata = WDATA;

        case (state_q)
            CLR_ALL: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = FILL;
                clr_cnt_d = clr_cnt_q + 9'd1;
                if (clr_cnt_q == LAST_CELL) begin
                    state_d = IDLE;
                end
            end
            CLR_ROW: begin
                ram_we    = 1'b1;
                ram_waddr = {crow_q, row_cnt_q};
                ram_wdata = FILL;
                row_cnt_d = row_cnt_q + 5'd1;
                if (row_cnt_q == LAST_COL) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (is_print(WDATA)) begin
                        ram_we = 1'b1;
                        if (curx_q == LAST_COL) begin
                            newline = 1'b1;
                        end else begin
                            curx_d = curx_q + 5'd1;
                        end
                    end else if (WDATA == C_LF) begin
                        newline = 1'b1;
                    end else if (WDATA == C_CR) begin
                        curx_d = '0;
                    end else if (WDATA == C_BS) begin
                        // Backspace never backs up into the previous row.
                        if (curx_q != '0) begin
                            curx_d    = curx_q - 5'd1;
                            ram_we    = 1'b1;
                            ram_waddr = {cur_prow, curx_q - 5'd1};
                            ram_wdata = FILL;
                        end
                    end
                end
            end
            default: begin
                state_d   = CLR_ALL;
                clr_cnt_d = '0;
            end
        endcase

        if (newline) begin
            curx_d = '0;
            if (cury_q != LAST_ROW) begin
                cury_d = cury_q + 4'd1;
            end else begin
                // The old top row becomes the new bottom row; blank it.
                crow_d    = top_q;
                top_d     = top_q + 4'd1;
                row_cnt_d = '0;
                state_d   = CLR_ROW;
            end
        end

        // Clear wins over everything; WREADY is already low so no byte lands.
        if (CLR) begin
            state_d   = CLR_ALL;
            clr_cnt_d = '0;
            curx_d    = '0;
            cury_d    = '0;
            top_d     = '0;
        end
    end

    text_ram #(
        .AW (9),
        .DW (8)
    ) u_ram (
        .clk_i   (CLK),
        .rst_ni  (NRST),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i ({rd_prow, CX}),
        .rdata_o (CHAR)
    );

    assign CURX = curx_q;
    assign CURY = cury_q;

endmodule

// File: tb/tb_text_buffer.sv
// tb/tb_text_buffer.sv - scoreboard bench for text_buffer
module tb_text_buffer;

    logic       CLK = 1'b0;
    logic       NRST;
    logic [4:0] CX;
    logic [3:0] CY;
    logic [7:0] CHAR;
    logic [7:0] WDATA;
    logic       WVALID;
    logic       WREADY;
    logic       CLR;
    logic [4:0] CURX;
    logic [3:0] CURY;

    text_buffer dut (
        .CLK    (CLK),
        .NRST   (NRST),
        .CX     (CX),
        .CY     (CY),
        .CHAR   (CHAR),
        .WDATA  (WDATA),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .CLR    (CLR),
        .CURX   (CURX),
        .CURY   (CURY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] x;
        logic [3:0] y;
        logic [7:0] v;
    } rd_t;

    rd_t  exp_q[$];
    logic rd_issue = 1'b0;
    logic rd_pipe  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge CLK) rd_pipe <= rd_issue;

    // Monitor: CHAR is valid the cycle after a read was issued.
    always @(negedge CLK) begin
        if (rd_pipe) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected: got %02h with no expected entry", CHAR);
            end else begin
                rd_t e;
                e = exp_q.pop_front();
                if (CHAR !== e.v) begin
                    n_fail++;
                    $display("FAIL read(%0d,%0d): got %02h expected %02h", e.x, e.y, CHAR, e.v);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic rd(input logic [4:0] x, input logic [3:0] y, input logic [7:0] v);
        rd_t e;
        e.x = x; e.y = y; e.v = v;
        exp_q.push_back(e);
        CX = x; CY = y; rd_issue = 1'b1;
        @(posedge CLK); #1;
        rd_issue = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        WDATA = b; WVALID = 1'b1;
        while (!WREADY && w < 1000) begin
            @(posedge CLK); #1; w++;
        end
        if (!WREADY) begin
            chk("send_timeout", w, -1);
        end else begin
            @(posedge CLK); #1;
        end
        WVALID = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int c;
        c = 0;
        while (!WREADY && c < 1000) begin
            @(posedge CLK); #1; c++;
        end
        chk(name, c, exp_cycles);
    endtask

    task automatic do_clear();
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        chk("clr_curx", CURX, 0);
        chk("clr_cury", CURY, 0);
        wait_ready("clr_ready_cycles", 512);
    endtask

    initial begin
        int c;
        NRST = 1'b0; CX = '0; CY = '0; WDATA = '0; WVALID = 1'b0; CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_char", CHAR, 8'h00);
        chk("rst_curx", CURX, 0);
        chk("rst_cury", CURY, 0);
        chk("rst_wready", WREADY, 0);

        // Power-up clear: WREADY rises 512 cycles after reset release.
        NRST = 1'b1;
        WDATA = 8'h41; WVALID = 1'b1;
        c = 0;
        while (!WREADY && c < 1000) begin
            @(posedge CLK); #1; c++;
        end
        chk("init_ready_cycles", c, 512);
        // Read issued on the same edge that accepts the first byte.
        exp_q.push_back('{x: 5'd7, y: 4'd3, v: 8'h20});
        CX = 5'd7; CY = 4'd3; rd_issue = 1'b1;
        @(posedge CLK); #1;
        rd_issue = 1'b0; WVALID = 1'b0;
        chk("a_curx", CURX, 1);
        rd(0, 0, 8'h41);

        // "AB" CR LF "C"
        send(8'h42); send(8'h0D); send(8'h0A); send(8'h43);
        rd(0, 0, 8'h41); rd(1, 0, 8'h42); rd(0, 1, 8'h43); rd(1, 1, 8'h20);
        chk("abc_curx", CURX, 1);
        chk("abc_cury", CURY, 1);

        // 33 x 'X' wraps onto row 1.
        do_clear();
        for (int i = 0; i < 33; i++) send(8'h58);
        rd(0, 0, 8'h58); rd(15, 0, 8'h58); rd(31, 0, 8'h58);
        rd(0, 1, 8'h58); rd(1, 1, 8'h20);
        chk("wrap_curx", CURX, 1);
        chk("wrap_cury", CURY, 1);

        // Scroll: 'Z' at (0,0), LF, 'W' at (0,1), then 15 LFs.
        do_clear();
        send(8'h5A); send(8'h0A); send(8'h57);
        for (int i = 0; i < 15; i++) send(8'h0A);
        chk("scroll_wready_now", WREADY, 0);
        wait_ready("scroll_ready_cycles", 32);
        chk("scroll_curx", CURX, 0);
        chk("scroll_cury", CURY, 15);
        rd(0, 0, 8'h57); rd(1, 0, 8'h20);
        rd(0, 15, 8'h20); rd(5, 15, 8'h20); rd(31, 15, 8'h20);
        send(8'h56);
        rd(0, 15, 8'h56); rd(0, 0, 8'h57);
        chk("scroll_v_curx", CURX, 1);

        // Backspace and discarded codes at (0,3).
        do_clear();
        send(8'h0A); send(8'h0A); send(8'h0A);
        send(8'h08);
        chk("bs0_curx", CURX, 0);
        chk("bs0_cury", CURY, 3);
        send(8'h07);
        chk("other_curx", CURX, 0);
        send(8'h51);
        rd(0, 3, 8'h51);
        chk("q_curx", CURX, 1);
        send(8'h08);
        rd(0, 3, 8'h20);
        chk("bs_curx", CURX, 0);
        chk("bs_cury", CURY, 3);

        // CLR in the middle of a row scroll with a byte pending.
        do_clear();
        for (int i = 0; i < 16; i++) send(8'h0A);
        repeat (5) @(posedge CLK);
        #1;
        WDATA = 8'h4B; WVALID = 1'b1; CLR = 1'b1;
        chk("clr_mid_wready", WREADY, 0);
        @(posedge CLK); #1;
        CLR = 1'b0;
        chk("clr_mid_curx", CURX, 0);
        chk("clr_mid_cury", CURY, 0);
        wait_ready("clr_mid_ready_cycles", 512);
        WVALID = 1'b0;
        chk("clr_mid_curx2", CURX, 0);
        rd(0, 0, 8'h20); rd(0, 15, 8'h20);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
